// File: rtl/wb_mem_pkg.sv
// Shared definitions for the Wishbone memory burst master: state encoding,
// byte-select constant and the default ack timeout.
package wb_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_FETCH = 3'd1,
        ST_WR_BUS   = 3'd2,
        ST_RD_BUS   = 3'd3,
        ST_RD_HOLD  = 3'd4,
        ST_FINISH   = 3'd5
    } wb_state_e;

    localparam logic [3:0] WB_SEL_ALL        = 4'hF;
    localparam int         WB_TIMEOUT_CYCLES = 255;

    // States in which stb is asserted and an ack is awaited.
    function automatic logic is_bus_state(input wb_state_e s);
        return (s == ST_WR_BUS) || (s == ST_RD_BUS);
    endfunction

endpackage

// File: rtl/wb_ack_timeout.sv
// Loadable down-counter with an expiry flag; expiry is reported on the
// cycle the counter sits at zero while enabled.
module wb_ack_timeout #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_en,
    output logic                 o_expired
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Down-counter: load has priority, saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= {CNT_WIDTH{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != {CNT_WIDTH{1'b0}})) begin
            r_cnt <= r_cnt - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = i_en & (r_cnt == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/wb_mem_burst_master.sv
// Wishbone burst initiator: reads or writes a run of consecutive words.
// Optional ack timeout enabled by defining WB_MEM_BURST_TIMEOUT_EN.
module wb_mem_burst_master
    import wb_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_INC       = 32'd1,
    parameter int          COUNT_WIDTH    = 24,
    parameter int          TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cmd_stb,
    output logic                   o_cmd_rdy,
    input  logic                   i_cmd_we,
    input  logic [31:0]            i_cmd_adr,
    input  logic [COUNT_WIDTH-1:0] i_cmd_count,
    input  logic                   i_wr_stb,
    input  logic [31:0]            i_wr_dat,
    output logic                   o_wr_rdy,
    output logic                   o_rd_stb,
    output logic [31:0]            o_rd_dat,
    input  logic                   i_rd_rdy,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_mem_we,
    output logic                   o_mem_stb,
    output logic                   o_mem_cyc,
    output logic [3:0]             o_mem_sel,
    output logic [31:0]            o_mem_adr,
    output logic [31:0]            o_mem_dat,
    input  logic [31:0]            i_mem_dat,
    input  logic                   i_mem_ack,
    input  logic                   i_mem_int,
    output logic                   o_int
);

    wb_state_e r_state;
    wb_state_e w_state_nxt;

    logic [31:0]            r_adr;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [31:0]            r_wdat;
    logic [31:0]            r_rdat;
    logic                   r_cmd_rdy;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_cyc;
    logic                   r_stb;
    logic                   r_we;
    logic                   r_rd_stb;
    logic                   r_int;

    logic w_cmd_acc;
    logic w_wr_take;
    logic w_wr_ack;
    logic w_rd_ack;
    logic w_rd_pop;
    logic w_last;
    logic w_expired;

    assign w_cmd_acc = i_cmd_stb & r_cmd_rdy;
    assign w_wr_take = (r_state == ST_WR_FETCH) & i_wr_stb;
    assign w_wr_ack  = (r_state == ST_WR_BUS) & i_mem_ack;
    assign w_rd_ack  = (r_state == ST_RD_BUS) & i_mem_ack;
    assign w_rd_pop  = (r_state == ST_RD_HOLD) & i_rd_rdy;
    assign w_last    = (r_cnt == {{(COUNT_WIDTH-1){1'b0}}, 1'b1});

`ifdef WB_MEM_BURST_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic r_err;

    // Reloaded whenever no ack is pending, so each bus phase gets a full budget.
    wb_ack_timeout #(
        .CNT_WIDTH (TO_W)
    ) u_ack_timeout (
        .clk        (clk),
        .rst        (rst),
        .i_load     (~is_bus_state(r_state)),
        .i_load_val (TO_LOAD),
        .i_en       (is_bus_state(r_state)),
        .o_expired  (w_expired)
    );

    // Sticky timeout flag, cleared by the next accepted command.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_cmd_acc) begin
            r_err <= 1'b0;
        end else if (w_expired && !i_mem_ack) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign o_err = r_err;
`else
    assign w_expired = 1'b0;
    assign o_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an ack arriving on the expiry cycle still completes the word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_cmd_acc) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_cmd_count == {COUNT_WIDTH{1'b0}}) begin
                    w_state_nxt = ST_FINISH;
                end else if (i_cmd_we) begin
                    w_state_nxt = ST_WR_FETCH;
                end else begin
                    w_state_nxt = ST_RD_BUS;
                end
            end
            ST_WR_FETCH: begin
                if (i_wr_stb) begin
                    w_state_nxt = ST_WR_BUS;
                end else begin
                    w_state_nxt = ST_WR_FETCH;
                end
            end
            ST_WR_BUS: begin
                if (i_mem_ack) begin
                    w_state_nxt = w_last ? ST_FINISH : ST_WR_FETCH;
                end else if (w_expired) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_WR_BUS;
                end
            end
            ST_RD_BUS: begin
                if (i_mem_ack) begin
                    w_state_nxt = ST_RD_HOLD;
                end else if (w_expired) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_state_nxt = ST_RD_BUS;
                end
            end
            ST_RD_HOLD: begin
                if (i_rd_rdy) begin
                    w_state_nxt = w_last ? ST_FINISH : ST_RD_BUS;
                end else begin
                    w_state_nxt = ST_RD_HOLD;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and bus controls, registered from the next state so outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_adr     <= 32'd0;
            r_cnt     <= {COUNT_WIDTH{1'b0}};
            r_wdat    <= 32'd0;
            r_rdat    <= 32'd0;
            r_cmd_rdy <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_int     <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_adr <= i_cmd_adr;
                r_cnt <= i_cmd_count;
            end else if (w_wr_ack || w_rd_pop) begin
                r_adr <= r_adr + ADDR_INC;
                r_cnt <= r_cnt - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_adr <= r_adr;
                r_cnt <= r_cnt;
            end

            r_wdat <= w_wr_take ? i_wr_dat : r_wdat;
            r_rdat <= w_rd_ack ? i_mem_dat : r_rdat;

            if (w_cmd_acc) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_FINISH) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end

            // Ready returns one cycle after the done pulse.
            r_cmd_rdy <= (w_state_nxt == ST_IDLE) && (r_state != ST_FINISH);
            r_done    <= (r_state == ST_FINISH);
            r_cyc     <= (w_state_nxt == ST_WR_FETCH) || (w_state_nxt == ST_WR_BUS) ||
                         (w_state_nxt == ST_RD_BUS)   || (w_state_nxt == ST_RD_HOLD);
            r_stb     <= is_bus_state(w_state_nxt);
            r_we      <= (w_state_nxt == ST_WR_BUS);
            r_rd_stb  <= (w_state_nxt == ST_RD_HOLD);
            r_int     <= i_mem_int;
        end
    end

    assign o_cmd_rdy = r_cmd_rdy;
    assign o_wr_rdy  = w_wr_take;
    assign o_rd_stb  = r_rd_stb;
    assign o_rd_dat  = r_rdat;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_mem_we  = r_we;
    assign o_mem_stb = r_stb;
    assign o_mem_cyc = r_cyc;
    assign o_mem_sel = WB_SEL_ALL;
    assign o_mem_adr = r_adr;
    assign o_mem_dat = r_wdat;
    assign o_int     = r_int;

endmodule
